otter_intr_csr: RTL and testbench

Interrupt and machine-CSR unit directly upstream of the OTTER control-unit FSM. It generates the FSM's `intr` input. It synchronises the asynchronous external interrupt line and latches a rising edge as pending. It also holds the machine CSRs `mstatus`, `mtvec`, `mepc` and `mip`, and updates them when the FSM reports an interrupt entry or an `mret`. Its `mtvec`/`mepc` outputs feed the PC-source mux.

---
 rtl/otter_pkg.sv | 21 ++
 rtl/otter_intr_csr_sync_edge_det.sv | 31 +++
 rtl/otter_intr_csr.sv | 141 ++++++++++++++
 tb/tb_otter_intr_csr.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared constants and types for the OTTER interrupt/CSR unit.
package otter_pkg;

    // Machine CSR addresses (ir[31:20] of a csrrw)
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // Bit positions inside mstatus / mip
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIP_MEIP     = 11;

    // Pending-interrupt latch states
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } pend_state_e;

endpackage

// File: rtl/otter_intr_csr_sync_edge_det.sv
// Multi-flop synchroniser with registered rising-edge detect.
// Reusable for any asynchronous level input (interrupt lines, buttons).
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic RST,
    input  logic d_async,
    output logic q_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the async input through the chain; keep one delayed copy of the output
    always_ff @(posedge clk) begin
        if (RST) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A held-high level produces a single-cycle rise only
    assign q_sync = sync_q[SYNC_STAGES-1];
    assign rise   = q_sync & ~prev_q;

endmodule

// File: rtl/otter_intr_csr.sv
// Interrupt request generation and machine CSRs (mstatus, mtvec, mepc, mip)
// feeding the OTTER control-unit FSM and PC-source mux.
//
// Pending latch states:
//   state | meaning
//   IDLE  | no external interrupt edge outstanding
//   PEND  | an edge has been seen and not yet taken by the FSM
module otter_intr_csr
    import otter_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              SYNC_STAGES = 2,
    parameter logic [XLEN-1:0] MTVEC_RST   = '0
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            irq_in,
    input  logic            int_taken,
    input  logic            mret_exec,
    input  logic [XLEN-1:0] pc,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wd,
    output logic [XLEN-1:0] csr_rd,
    output logic            intr,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_o
);

    // Word alignment: mtvec and mepc never hold a non-zero low pair
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic            irq_sync;
    logic            irq_rise;

    pend_state_e     state_q, state_d;
    logic            pend;

    logic            mie_q,   mie_d;
    logic            mpie_q,  mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q,  mepc_d;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk     (clk),
        .RST     (RST),
        .d_async (irq_in),
        .q_sync  (irq_sync),
        .rise    (irq_rise)
    );

    // Pending latch state register
    always_ff @(posedge clk) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Pending latch next state; a new edge beats int_taken so it is never lost
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (irq_rise) state_d = PEND;
            PEND:    if (int_taken && !irq_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pending latch output decode
    always_comb begin
        pend = (state_q == PEND);
    end

    // CSR register bank
    always_ff @(posedge clk) begin
        if (RST) begin
            mie_q   <= 1'b0;
            mpie_q  <= 1'b0;
            mtvec_q <= MTVEC_RST;
            mepc_q  <= '0;
        end else begin
            mie_q   <= mie_d;
            mpie_q  <= mpie_d;
            mtvec_q <= mtvec_d;
            mepc_q  <= mepc_d;
        end
    end

    // CSR next state: trap entry beats mret beats software writes on mstatus/mepc
    always_comb begin
        mie_d   = mie_q;
        mpie_d  = mpie_q;
        mtvec_d = mtvec_q;
        mepc_d  = mepc_q;

        if (int_taken) begin
            mepc_d = pc & ALIGN_MASK;
            mpie_d = mie_q;
            mie_d  = 1'b0;
        end else if (mret_exec) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (csr_we) begin
            if (csr_addr == CSR_MSTATUS) begin
                mie_d  = csr_wd[MSTATUS_MIE];
                mpie_d = csr_wd[MSTATUS_MPIE];
            end
            if (csr_addr == CSR_MEPC) begin
                mepc_d = csr_wd & ALIGN_MASK;
            end
        end

        // mtvec has no hardware updater, so software writes always land
        if (csr_we && csr_addr == CSR_MTVEC) begin
            mtvec_d = csr_wd & ALIGN_MASK;
        end
    end

    // CSR read mux, showing contents before this cycle's update
    always_comb begin
        csr_rd = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rd[MSTATUS_MIE]  = mie_q;
                csr_rd[MSTATUS_MPIE] = mpie_q;
            end
            CSR_MTVEC:   csr_rd = mtvec_q;
            CSR_MEPC:    csr_rd = mepc_q;
            CSR_MIP:     csr_rd[MIP_MEIP] = pend;
            default:     csr_rd = '0;
        endcase
    end

    assign intr    = pend & mie_q;
    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;
    assign mie_o   = mie_q;

endmodule

// File: tb/tb_otter_intr_csr.sv
// Scoreboard bench for otter_intr_csr: the driver issues one set of inputs per
// cycle, predicts the outputs from a behavioural model and queues them; the
// monitor pops and compares at the falling edge of the same cycle.
module tb_otter_intr_csr;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        irq_in = 1'b0;
    logic        int_taken = 1'b0;
    logic        mret_exec = 1'b0;
    logic [31:0] pc = '0;
    logic        csr_we = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wd = '0;
    logic [31:0] csr_rd;
    logic        intr;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mie_o;

    otter_intr_csr #(
        .XLEN        (32),
        .SYNC_STAGES (S),
        .MTVEC_RST   (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .irq_in    (irq_in),
        .int_taken (int_taken),
        .mret_exec (mret_exec),
        .pc        (pc),
        .csr_we    (csr_we),
        .csr_addr  (csr_addr),
        .csr_wd    (csr_wd),
        .csr_rd    (csr_rd),
        .intr      (intr),
        .mtvec_o   (mtvec_o),
        .mepc_o    (mepc_o),
        .mie_o     (mie_o)
    );

    always #5 clk = ~clk;

    // The FSM never issues both events in one cycle
    always @(posedge clk) begin
        assert (!(int_taken && mret_exec));
    end

    typedef struct {
        bit          chk;
        int          n;
        logic        intr;
        logic        mie;
        logic [31:0] mepc;
        logic [31:0] mtvec;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    // Behavioural model state
    bit          m_valid = 0;
    logic        m_pend, m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mepc;
    logic        m_hist [0:S];   // m_hist[i] = irq_in sampled i+1 edges ago

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h344: return 32'(m_pend) << 11;
            default: return 32'h0;
        endcase
    endfunction

    task automatic cyc(input logic r, input logic irq, input logic it, input logic mr,
                       input logic [31:0] pcv, input logic we, input logic [11:0] a,
                       input logic [31:0] wd);
        exp_t e;
        logic rise;
        @(posedge clk);
        #1;
        RST = r; irq_in = irq; int_taken = it; mret_exec = mr;
        pc = pcv; csr_we = we; csr_addr = a; csr_wd = wd;

        e.chk   = m_valid;
        e.n     = cyc_n;
        e.intr  = m_pend & m_mie;
        e.mie   = m_mie;
        e.mepc  = m_mepc;
        e.mtvec = m_mtvec;
        e.rd    = model_read(a);
        sb.push_back(e);
        cyc_n++;

        if (r) begin
            m_valid = 1;
            m_pend = 0; m_mie = 0; m_mpie = 0; m_mtvec = 32'h0; m_mepc = 32'h0;
            for (int i = 0; i <= S; i++) m_hist[i] = 1'b0;
        end else begin
            // A 0->1 step of the input seen S edges ago becomes pending now
            rise = m_hist[S-1] & ~m_hist[S];
            if (rise) m_pend = 1;
            else if (it) m_pend = 0;

            if (it) begin
                m_mepc = {pcv[31:2], 2'b00};
                m_mpie = m_mie;
                m_mie  = 0;
            end else if (mr) begin
                m_mie  = m_mpie;
                m_mpie = 1;
            end else if (we && a == 12'h300) begin
                m_mie  = wd[3];
                m_mpie = wd[7];
            end else if (we && a == 12'h341) begin
                m_mepc = {wd[31:2], 2'b00};
            end
            if (we && a == 12'h305) m_mtvec = {wd[31:2], 2'b00};

            for (int i = S; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = irq;
        end
    endtask

    task automatic idle(input logic irq, input logic [11:0] a, input int n);
        for (int i = 0; i < n; i++) cyc(0, irq, 0, 0, 32'h0, 0, a, 32'h0);
    endtask

    function automatic void cmp(input string nm, input int n,
                                input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, n, got, exp);
        end
    endfunction

    // Monitor: compare the DUT against the queued prediction for this cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    cmp("intr",    e.n, 32'(intr),  32'(e.intr));
                    cmp("mie_o",   e.n, 32'(mie_o), 32'(e.mie));
                    cmp("mepc_o",  e.n, mepc_o,     e.mepc);
                    cmp("mtvec_o", e.n, mtvec_o,    e.mtvec);
                    cmp("csr_rd",  e.n, csr_rd,     e.rd);
                end
            end
        end
    end

    initial begin
        int          hold;
        logic        irq_r, it, mr, we, r;
        logic [11:0] a;
        logic [31:0] wd;

        // 1: reset with irq high, then pending appears but intr stays low
        cyc(1, 1, 0, 0, 32'h0, 0, 12'h300, 32'h0);
        cyc(1, 1, 0, 0, 32'h0, 0, 12'h300, 32'h0);
        idle(1, 12'h300, 1);
        idle(1, 12'h344, 5);

        // clear pending, drop irq
        idle(0, 12'h344, 4);
        cyc(0, 0, 1, 0, 32'h0, 0, 12'h344, 32'h0);
        idle(0, 12'h344, 2);

        // 2: enable, set mtvec, then watch the latency of a new edge
        cyc(0, 0, 0, 0, 32'h0, 1, 12'h300, 32'h0000_0008);
        cyc(0, 0, 0, 0, 32'h0, 1, 12'h305, 32'h0000_0103);
        idle(0, 12'h305, 1);
        idle(1, 12'h344, 5);

        // 3: trap entry then return
        cyc(0, 1, 1, 0, 32'h0000_0244, 0, 12'h300, 32'h0);
        idle(1, 12'h300, 1);
        idle(1, 12'h344, 1);
        cyc(0, 1, 0, 1, 32'h0, 0, 12'h300, 32'h0);
        idle(1, 12'h300, 1);

        // 4: pend an edge, then take it in the same cycle a second edge rises
        idle(0, 12'h344, 4);
        idle(1, 12'h344, 4);
        idle(0, 12'h344, 4);
        idle(1, 12'h344, 2);
        cyc(0, 1, 1, 0, 32'h0000_0400, 0, 12'h344, 32'h0);
        idle(1, 12'h344, 2);
        cyc(0, 1, 0, 1, 32'h0, 0, 12'h344, 32'h0);
        idle(1, 12'h344, 2);

        // 5: mret beats a coincident mstatus write; unmapped write is ignored
        cyc(0, 1, 1, 0, 32'h0000_0500, 0, 12'h300, 32'h0);
        cyc(0, 1, 0, 1, 32'h0, 1, 12'h300, 32'h0);
        idle(1, 12'h300, 1);
        cyc(0, 1, 0, 0, 32'h0, 1, 12'h7C0, 32'hFFFF_FFFF);
        idle(1, 12'h7C0, 1);
        idle(1, 12'h300, 1);

        // 6: pending + enabled + mepc set, then reset with irq held high
        idle(0, 12'h344, 4);
        cyc(0, 0, 0, 0, 32'h0, 1, 12'h341, 32'h0000_0300);
        idle(1, 12'h344, 4);
        cyc(1, 1, 0, 0, 32'h0, 0, 12'h344, 32'h0);
        cyc(0, 1, 0, 0, 32'h0, 1, 12'h300, 32'h0000_0008);
        idle(1, 12'h344, 8);

        // Random traffic
        hold = 0;
        irq_r = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                irq_r = 1'($urandom_range(0, 1));
                hold  = $urandom_range(1, 12);
            end
            hold--;
            it = ((m_pend & m_mie) && $urandom_range(0, 3) == 0) || $urandom_range(0, 40) == 0;
            mr = !it && $urandom_range(0, 15) == 0;
            we = $urandom_range(0, 3) == 0;
            case ($urandom_range(0, 5))
                0: a = 12'h300;
                1: a = 12'h305;
                2: a = 12'h341;
                3: a = 12'h344;
                4: a = 12'h7C0;
                default: a = 12'($urandom);
            endcase
            if (mr && we && a == 12'h341) we = 0;
            wd = $urandom;
            r  = $urandom_range(0, 299) == 0;
            cyc(r, irq_r, it, mr, $urandom, we, a, wd);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
